// File: rtl/keyed_load_modulator_if.sv
// rtl/keyed_load_modulator_if.sv - control and load-bank bundle for keyed_load_modulator
//
// Purpose: groups the key capture, run control and load outputs of the
// keyed load modulator so that they travel as one port.
// Signals:
//   key        key to capture (KEY_W bits)
//   key_vld    capture strobe for key
//   en         run enable
//   mode       load source: 0 = key XOR LFSR, 1 = raw key
//   load       registered load bank (CHUNK*FANOUT bits)
//   chunk_idx  index of the chunk currently driven on load
//   active     high while the modulator is running
// Modports: master drives the controls, slave is the modulator itself.
interface keyed_load_modulator_if #(
    parameter int KEY_W  = 128,
    parameter int CHUNK  = 8,
    parameter int FANOUT = 8,
    parameter int IDX_W  = ((KEY_W / CHUNK) > 1) ? $clog2(KEY_W / CHUNK) : 1
);
    logic [KEY_W-1:0]        key;
    logic                    key_vld;
    logic                    en;
    logic                    mode;
    logic [CHUNK*FANOUT-1:0] load;
    logic [IDX_W-1:0]        chunk_idx;
    logic                    active;

    modport master (
        output key, key_vld, en, mode,
        input  load, chunk_idx, active
    );

    modport slave (
        input  key, key_vld, en, mode,
        output load, chunk_idx, active
    );
endinterface

// File: rtl/keyed_load_modulator.sv
// rtl/keyed_load_modulator.sv - key-dependent switching-load generator with epoch chunk walk
//
// Purpose: captures a key and drives a registered fan-out load bank from one
// CHUNK-bit slice of the key at a time, optionally XOR-masked by an internal
// Fibonacci LFSR. Each slice is held for EPOCH_LEN running cycles before the
// walk moves to the next slice, wrapping after the last one.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   keyed_load_modulator_if.slave: key/key_vld/en/mode in,
//         load/chunk_idx/active out (all outputs registered)
module keyed_load_modulator #(
    parameter int                KEY_W     = 128,
    parameter int                CHUNK     = 8,
    parameter int                FANOUT    = 8,
    parameter int                LFSR_W    = 20,
    parameter logic [LFSR_W-1:0] TAPS      = 20'h90000,
    parameter logic [LFSR_W-1:0] SEED      = 20'h00001,
    parameter int                EPOCH_LEN = 256
) (
    input  logic clk,
    input  logic rst,
    keyed_load_modulator_if.slave bus
);
    localparam int N_CHUNKS = KEY_W / CHUNK;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int CNT_W    = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam int LOAD_W   = CHUNK * FANOUT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t                          state;
    logic [N_CHUNKS-1:0][CHUNK-1:0]  key_q;
    logic [LFSR_W-1:0]               lfsr;
    logic [CNT_W-1:0]                epoch_cnt;
    // chunk_ptr selects the slice for the next load update; chunk_idx reports
    // the slice of the load currently on the bank, so it moves together with
    // the first load of a new chunk rather than one edge earlier.
    logic [IDX_W-1:0]                chunk_ptr;
    logic [IDX_W-1:0]                chunk_idx_q;
    logic [LOAD_W-1:0]               load_q;
    logic                            active_q;

    logic [CHUNK-1:0]                mask;
    logic [CHUNK-1:0]                bits;
    logic [LOAD_W-1:0]               load_nxt;
    logic [LFSR_W-1:0]               lfsr_step;
    logic                            epoch_last;
    logic                            chunk_last;

    always_comb begin
        mask      = bus.mode ? '0 : lfsr[CHUNK-1:0];
        bits      = key_q[chunk_ptr] ^ mask;
        load_nxt  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            for (int j = 0; j < FANOUT; j++) begin
                load_nxt[i*FANOUT+j] = bits[i];
            end
        end
        lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
        // The all-zero state is a lock-up point; fall back to the seed.
        if (lfsr_step == '0) begin
            lfsr_step = SEED;
        end
    end

    assign epoch_last = (epoch_cnt == CNT_W'(EPOCH_LEN - 1));
    assign chunk_last = (chunk_ptr == IDX_W'(N_CHUNKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            key_q       <= '0;
            lfsr        <= SEED;
            epoch_cnt   <= '0;
            chunk_ptr   <= '0;
            chunk_idx_q <= '0;
            load_q      <= '0;
            active_q    <= 1'b0;
        end else if (bus.key_vld) begin
            // Capture restarts the walk at chunk 0 from any state; the LFSR
            // keeps running from wherever it was.
            key_q       <= bus.key;
            epoch_cnt   <= '0;
            chunk_ptr   <= '0;
            chunk_idx_q <= '0;
            load_q      <= '0;
            state       <= bus.en ? S_RUN : S_PAUSE;
            active_q    <= bus.en;
        end else begin
            case (state)
                S_IDLE: begin
                    load_q   <= '0;
                    active_q <= 1'b0;
                end
                S_RUN: begin
                    if (!bus.en) begin
                        state    <= S_PAUSE;
                        load_q   <= '0;
                        active_q <= 1'b0;
                    end else begin
                        load_q      <= load_nxt;
                        chunk_idx_q <= chunk_ptr;
                        lfsr        <= lfsr_step;
                        active_q    <= 1'b1;
                        if (epoch_last) begin
                            epoch_cnt <= '0;
                            chunk_ptr <= chunk_last ? '0 : chunk_ptr + 1'b1;
                        end else begin
                            epoch_cnt <= epoch_cnt + 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    // Resuming only re-arms RUN; the next load update comes on
                    // the following edge, with counters as they were frozen.
                    load_q <= '0;
                    if (bus.en) begin
                        state    <= S_RUN;
                        active_q <= 1'b1;
                    end else begin
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    load_q   <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load      = load_q;
    assign bus.chunk_idx = chunk_idx_q;
    assign bus.active    = active_q;
endmodule

// File: doc/keyed_load_modulator.md
# keyed_load_modulator

Parametrised successor to the key-dependent switching-load generator used in the AES trojan benchmarks. It captures a key, then drives a registered fan-out load bank from one key chunk at a time, optionally masked by an internal LFSR. It walks through every chunk of the key on a fixed epoch schedule, with enable/pause and mode control. It sits beside the AES core as a ground-truth leakage source for the detection flow's power-analysis experiments.

## Interface
- KEY_W, 128: key width; must be a multiple of CHUNK.
- CHUNK, 8: key bits driven per epoch.
- FANOUT, 8: register copies per key bit.
- LFSR_W, 20: LFSR width; must be ≥ CHUNK.
- TAPS, 20'h90000: feedback tap mask (x^20+x^17+1).
- SEED, 20'h00001: LFSR reset value; must be nonzero.
- EPOCH_LEN, 256: RUN cycles per chunk; must be ≥ 1.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key  in  KEY_W  key to capture.
- key_vld  in  1  capture strobe for key.
- en  in  1  run enable.
- mode  in  1  load source: 0 = key XOR LFSR, 1 = raw key.
- load  out  CHUNK*FANOUT  registered load bank.
- chunk_idx  out  max(1,clog2(KEY_W/CHUNK))  index of the chunk currently driven.
- active  out  1  high while in RUN.

## Operation
- Reset values: state IDLE; load 0; chunk_idx 0; active 0; epoch_cnt 0; lfsr SEED; key_q 0.
- States:
  - IDLE: load held at 0.
  - RUN: load is updated every cycle.
  - PAUSE: load is 0, and lfsr, epoch_cnt and chunk_idx are frozen.
- Key capture:
  - key_vld=1 in any state: key_q←key, chunk_idx←0, epoch_cnt←0, load←0.
  - Next state is RUN if en=1, else PAUSE.
  - lfsr is not reseeded by key capture.
- RUN, each cycle:
  - For i in 0..CHUNK-1 and j in 0..FANOUT-1: load[i*FANOUT+j] ← key_q[chunk_idx*CHUNK+i] XOR (mode ? 0 : lfsr[i]).
  - chunk_idx and lfsr values used are those before this edge's update.
  - lfsr ← {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}; if the result would be all-zero, it loads SEED instead.
  - epoch_cnt increments. At EPOCH_LEN-1 it wraps to 0 and chunk_idx increments, wrapping from KEY_W/CHUNK-1 to 0.
- State transitions:
  - RUN with en=0 → PAUSE.
  - PAUSE with en=1 → RUN; counters resume from their frozen values.
  - IDLE is left only via key_vld.
- mode is sampled every RUN cycle; changing it mid-epoch takes effect on the next load update.

## Timing
- Key capture: key_vld at edge T captures the key. active=1 from T+1 if en=1. The first chunk-0 load appears after edge T+1.
- Epochs: each chunk is visible on load for exactly EPOCH_LEN consecutive RUN edges. chunk_idx changes on the same edge as the first load of the new chunk.
- en low: when en is sampled low at edge T, load=0 and active=0 after T. When en is sampled high at T', the next load update happens at T'+1.
- Priority: rst > key_vld > en/epoch logic.
  - key_vld coinciding with an epoch wrap restarts at chunk 0, epoch_cnt 0.
  - key_vld with en=0 goes to PAUSE with the key captured.
- rst mid-RUN returns all state to reset values on that edge; key_q is cleared.
- Single-chunk configuration (KEY_W=CHUNK): chunk_idx stays 0; epochs still count.

## Test plan
All scenarios use KEY_W=16, CHUNK=8, FANOUT=2, EPOCH_LEN=4 unless stated.
- **Raw walk:** rst, then key=16'hA55A, key_vld=1, en=1, mode=1.
  - Edges T+1..T+4: load=16'h33CC, chunk_idx=0.
  - Edges T+5..T+8: load=16'hCC33, chunk_idx=1.
  - Edge T+9: load=16'h33CC, chunk_idx=0 (wrap).
- **Masked:** key=16'h0000, mode=0, default LFSR.
  - Successive load values: 16'h0003, 16'h000C, 16'h0030, 16'h00C0.
  - active=1 throughout.
- **Pause:** during the raw walk, drop en for 3 cycles after the 2nd load of chunk 0.
  - load=0 and active=0 for those cycles.
  - On resume, chunk 0 appears for exactly 2 more loads, then chunk 1.
- **Collision:** assert key_vld=1 with key=16'hFF00 on the epoch-wrap edge of chunk 0.
  - load=0 on that edge.
  - Then 16'h0000 ×4 (chunk 0), then 16'hFFFF (chunk 1).
- **Reset mid-run:** assert rst during chunk 1.
  - Next cycle: load=0, chunk_idx=0, active=0, lfsr=SEED.
  - The block stays IDLE despite en=1 until key_vld.
- **Defaults sweep:** defaults, random 128-bit key, mode=1.
  - load matches 8-fold replication of key[8k+7:8k] for k=0..15, each held 256 cycles, then wraps to k=0.
